digital_in_event_packer: RTL and testbench
==========================================

DIGITAL_IN_EVENT_PACKER -- requirements
Module: digital_in_event_packer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set event FIFO depth in entries; legal values 2, 4, 8, 16.
REQ-002 Port i_clk input 1 SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port i_rst input 1 SHALL be the reset, synchronous and active-high.
REQ-004 Port i_d input 8 SHALL carry the already-synchronized digital input word, one bit per breakout channel.
REQ-005 Port i_en input 1 SHALL gate event generation; 0 = no events pushed.
REQ-006 Port o_valid output 1 SHALL indicate an event word is presented.
REQ-007 Port i_ready input 1 SHALL indicate the consumer accepts the presented event.
REQ-008 Port o_port output 8 SHALL carry the input word captured with the event.
REQ-009 Port o_timestamp output 32 SHALL carry the timestamp captured with the event.
REQ-010 Port o_count output 5 SHALL report current FIFO occupancy, 0..DEPTH.
REQ-011 Port o_dropped output 16 SHALL count events discarded because the FIFO was full.

Function
REQ-012 Free-running 32-bit timestamp counter SHALL increment by 1 every cycle and wrap 0xFFFFFFFF -> 0x00000000.
REQ-013 8-bit previous-value register SHALL load i_d every cycle regardless of i_en.
REQ-014 Change event SHALL be raised in a cycle where i_en=1 and i_d != previous-value register.
REQ-015 Enable event SHALL be raised in the first cycle i_en=1 after a cycle with i_en=0 (or after reset), even if i_d unchanged.
REQ-016 Change and enable event in the same cycle SHALL produce exactly one push.
REQ-017 Push SHALL store {i_d, timestamp counter value of that same cycle}.
REQ-018 Latency: pushed event into an empty FIFO SHALL appear with o_valid=1 in the next cycle.
REQ-019 o_valid SHALL equal (o_count != 0).
REQ-020 Pop SHALL occur in a cycle where o_valid=1 and i_ready=1; next entry (if any) presented the following cycle.
REQ-021 While o_valid=1 and i_ready=0, o_port and o_timestamp SHALL hold stable.
REQ-022 i_ready while o_valid=0 SHALL have no effect.
REQ-023 Output ordering SHALL be strict FIFO order of pushes.
REQ-024 Push with FIFO full and no pop in that cycle SHALL be discarded and o_dropped incremented by 1.
REQ-025 Push and pop in the same cycle with FIFO full SHALL both succeed; o_count stays DEPTH, no drop.
REQ-026 Push and pop in the same cycle with 0 < o_count < DEPTH SHALL leave o_count unchanged.
REQ-027 o_dropped SHALL saturate at 0xFFFF.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-029 i_en=0 SHALL not flush the FIFO; stored events remain poppable.

Reset
REQ-030 i_rst=1 SHALL, at the next rising edge, clear timestamp counter, previous-value register, pointers, o_count, o_dropped to 0.
REQ-031 During and after reset: o_valid=0, o_port=0x00, o_timestamp=0x00000000 until the first push.
REQ-032 Reset mid-operation SHALL discard all stored events; i_rst has priority over push, pop and i_en.
REQ-033 Enable-event tracking SHALL treat the post-reset state as i_en=0.

Verification
REQ-034 Reset, i_en=1, i_d=0x00 held, i_ready=1 -> one enable event {0x00, ts=0} (cycle after reset release), then no further events.
REQ-035 i_en=1, i_d 0x00->0x05 at timestamp 100, i_ready=1 -> o_valid next cycle with o_port=0x05, o_timestamp=100, o_count=1 then 0.
REQ-036 DEPTH=4, i_ready=0, six single-cycle toggles -> o_count=4, o_dropped=2; then i_ready=1 -> four events in push order, timestamps ascending.
REQ-037 FIFO full, i_ready=1 and change on the same cycle -> no drop, o_count stays 4, o_dropped unchanged.
REQ-038 Timestamp preloaded near wrap (run 2^32-2 cycles or force), change at 0xFFFFFFFF and 0x00000000 -> two events carrying those exact values.
REQ-039 Three events queued, i_rst=1 one cycle -> o_valid=0, o_count=0, o_dropped=0 next cycle; i_en=0 toggles of i_d -> no events.

Source files
------------

// File: rtl/digital_in_event_packer.sv
// digital_in_event_packer: timestamps input-word changes and enables into a FIFO drained by valid/ready
// Ports: i_clk clock; i_rst sync active-high reset; i_d synchronized input word; i_en event gate;
//        o_valid/i_ready/o_port/o_timestamp event stream; o_count occupancy; o_dropped overflow count
module digital_in_event_packer #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_d,
    input  logic        i_en,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_port,
    output logic [31:0] o_timestamp,
    output logic [4:0]  o_count,
    output logic [15:0] o_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] LP_FULL = 5'(DEPTH);

    logic [31:0]   r_ts;
    logic [7:0]    r_prev;
    logic          r_en_d;
    logic [39:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [4:0]    r_count;
    logic [15:0]   r_dropped;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;
    logic [39:0]   w_head;

    // r_en_d clears on reset, so the first enabled cycle afterwards always raises an enable event
    assign w_push = i_en && ((i_d != r_prev) || !r_en_d);
    assign w_full = r_count == LP_FULL;
    assign w_pop  = o_valid && i_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    assign w_head      = r_mem[r_rp];
    assign o_valid     = r_count != 5'd0;
    // memory is not reset; gating keeps the outputs at zero while nothing is stored
    assign o_port      = o_valid ? w_head[39:32] : 8'h00;
    assign o_timestamp = o_valid ? w_head[31:0] : 32'h0;
    assign o_count     = r_count;
    assign o_dropped   = r_dropped;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ts      <= 32'h0;
            r_prev    <= 8'h00;
            r_en_d    <= 1'b0;
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= 5'd0;
            r_dropped <= 16'h0;
        end else begin
            r_ts    <= r_ts + 32'd1;
            r_prev  <= i_d;
            r_en_d  <= i_en;
            r_count <= r_count + 5'(w_wr) - 5'(w_pop);
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr && !i_rst) r_mem[r_wp] <= {i_d, r_ts};
    end
endmodule

// File: tb/tb_digital_in_event_packer.sv
// tb_digital_in_event_packer: directed checks of the event packer with DEPTH=4
module tb_digital_in_event_packer;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_d = 8'h00;
    logic        i_en = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_valid;
    logic [7:0]  o_port;
    logic [31:0] o_timestamp;
    logic [4:0]  o_count;
    logic [15:0] o_dropped;
    int n_vec = 0;
    int n_bad = 0;

    digital_in_event_packer #(.DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_d), .i_en(i_en), .o_valid(o_valid),
        .i_ready(i_ready), .o_port(o_port), .o_timestamp(o_timestamp),
        .o_count(o_count), .o_dropped(o_dropped)
    );

    always #5 i_clk = ~i_clk;

    // leaves the bench mid-cycle of the first post-reset cycle (timestamp 0)
    task automatic do_reset(input logic en, input logic rdy);
        @(negedge i_clk);
        i_rst = 1'b1; i_en = en; i_d = 8'h00; i_ready = rdy;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_en = 1'b1; i_d = 8'hFF; i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", o_valid); end
        n_vec++; if (o_port !== 8'h00) begin n_bad++; $display("FAIL rst_port got %h want 00", o_port); end
        n_vec++; if (o_timestamp !== 32'h0) begin n_bad++; $display("FAIL rst_ts got %h want 0", o_timestamp); end
        n_vec++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", o_count); end
        n_vec++; if (o_dropped !== 16'd0) begin n_bad++; $display("FAIL rst_dropped got %0d want 0", o_dropped); end
    endtask

    task automatic test_enable_event;
        do_reset(1'b1, 1'b1);
        @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL en_valid got %0b want 1", o_valid); end
        n_vec++; if (o_port !== 8'h00) begin n_bad++; $display("FAIL en_port got %h want 00", o_port); end
        n_vec++; if (o_timestamp !== 32'd0) begin n_bad++; $display("FAIL en_ts got %0d want 0", o_timestamp); end
        n_vec++; if (o_count !== 5'd1) begin n_bad++; $display("FAIL en_count got %0d want 1", o_count); end
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            n_vec++; if (o_count !== 5'd0 || o_valid !== 1'b0) begin n_bad++; $display("FAIL en_quiet cnt got %0d/%0b want 0/0", o_count, o_valid); end
        end
    endtask

    task automatic test_change;
        do_reset(1'b1, 1'b1);
        repeat (100) @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL chg_idle got %0b want 0", o_valid); end
        i_d = 8'h05;
        @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL chg_valid got %0b want 1", o_valid); end
        n_vec++; if (o_port !== 8'h05) begin n_bad++; $display("FAIL chg_port got %h want 05", o_port); end
        n_vec++; if (o_timestamp !== 32'd100) begin n_bad++; $display("FAIL chg_ts got %0d want 100", o_timestamp); end
        n_vec++; if (o_count !== 5'd1) begin n_bad++; $display("FAIL chg_count got %0d want 1", o_count); end
        @(negedge i_clk);
        n_vec++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL chg_drain got %0d want 0", o_count); end
    endtask

    task automatic test_overflow;
        logic [7:0]  vals [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
        logic [7:0]  exp_p [4] = '{8'h03, 8'h07, 8'h0F, 8'h7F};
        logic [31:0] exp_t [4] = '{32'd3, 32'd4, 32'd5, 32'd9};
        do_reset(1'b1, 1'b1);
        repeat (2) @(negedge i_clk);
        i_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_d = vals[k];
            @(negedge i_clk);
        end
        n_vec++; if (o_count !== 5'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", o_count); end
        n_vec++; if (o_dropped !== 16'd2) begin n_bad++; $display("FAIL ovf_dropped got %0d want 2", o_dropped); end
        n_vec++; if (o_port !== 8'h01 || o_timestamp !== 32'd2) begin n_bad++; $display("FAIL ovf_head got %h@%0d want 01@2", o_port, o_timestamp); end
        @(negedge i_clk);
        n_vec++; if (o_port !== 8'h01 || o_timestamp !== 32'd2 || o_count !== 5'd4) begin n_bad++; $display("FAIL ovf_hold got %h@%0d n%0d want 01@2 n4", o_port, o_timestamp, o_count); end
        i_ready = 1'b1; i_d = 8'h7F;
        @(negedge i_clk);
        n_vec++; if (o_dropped !== 16'd2) begin n_bad++; $display("FAIL full_pushpop_dropped got %0d want 2", o_dropped); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (o_port !== exp_p[k] || o_timestamp !== exp_t[k] || o_count !== 5'(4 - k)) begin
                n_bad++; $display("FAIL drain%0d got %h@%0d n%0d want %h@%0d n%0d", k, o_port, o_timestamp, o_count, exp_p[k], exp_t[k], 4 - k);
            end
            @(negedge i_clk);
        end
        n_vec++; if (o_valid !== 1'b0 || o_count !== 5'd0) begin n_bad++; $display("FAIL drain_end got %0b n%0d want 0 n0", o_valid, o_count); end
    endtask

    task automatic test_wrap;
        do_reset(1'b1, 1'b1);
        repeat (2) @(negedge i_clk);
        force dut.r_ts = 32'hFFFF_FFFD;
        #1 release dut.r_ts;
        repeat (2) @(negedge i_clk);
        i_d = 8'h01;
        @(negedge i_clk);
        n_vec++; if (o_port !== 8'h01 || o_timestamp !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_hi got %h@%h want 01@ffffffff", o_port, o_timestamp); end
        i_d = 8'h02;
        @(negedge i_clk);
        n_vec++; if (o_port !== 8'h02 || o_timestamp !== 32'h0 || o_count !== 5'd1) begin n_bad++; $display("FAIL wrap_lo got %h@%h n%0d want 02@00000000 n1", o_port, o_timestamp, o_count); end
        @(negedge i_clk);
        n_vec++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL wrap_end got %0d want 0", o_count); end
    endtask

    task automatic test_en_gate;
        do_reset(1'b1, 1'b0);
        @(negedge i_clk);
        i_en = 1'b0; i_d = 8'hAA;
        @(negedge i_clk);
        i_d = 8'h55;
        @(negedge i_clk);
        n_vec++; if (o_count !== 5'd1 || o_port !== 8'h00) begin n_bad++; $display("FAIL gate_keep got n%0d %h want n1 00", o_count, o_port); end
        i_en = 1'b1; i_d = 8'h11;
        @(negedge i_clk);
        n_vec++; if (o_count !== 5'd2) begin n_bad++; $display("FAIL gate_single_push got %0d want 2", o_count); end
        i_ready = 1'b1;
        @(negedge i_clk);
        n_vec++; if (o_port !== 8'h11 || o_timestamp !== 32'd3) begin n_bad++; $display("FAIL gate_reen got %h@%0d want 11@3", o_port, o_timestamp); end
        @(negedge i_clk);
        n_vec++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL gate_end got %0d want 0", o_count); end
    endtask

    task automatic test_reset_mid;
        do_reset(1'b1, 1'b0);
        for (int k = 1; k < 6; k++) begin
            @(negedge i_clk);
            i_d = 8'(k);
        end
        @(negedge i_clk);
        n_vec++; if (o_count !== 5'd4 || o_dropped !== 16'd2) begin n_bad++; $display("FAIL mid_pre got n%0d d%0d want n4 d2", o_count, o_dropped); end
        i_rst = 1'b1; i_ready = 1'b1; i_d = 8'h99;
        @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b0 || o_count !== 5'd0) begin n_bad++; $display("FAIL mid_clear got %0b n%0d want 0 n0", o_valid, o_count); end
        n_vec++; if (o_dropped !== 16'd0) begin n_bad++; $display("FAIL mid_dropped got %0d want 0", o_dropped); end
        n_vec++; if (o_port !== 8'h00 || o_timestamp !== 32'h0) begin n_bad++; $display("FAIL mid_out got %h@%0d want 00@0", o_port, o_timestamp); end
        i_rst = 1'b0; i_en = 1'b0; i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_d = 8'(k * 3 + 1);
            @(negedge i_clk);
            n_vec++; if (o_count !== 5'd0) begin n_bad++; $display("FAIL mid_noen%0d got %0d want 0", k, o_count); end
        end
        i_en = 1'b1;
        @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b1 || o_port !== 8'h07 || o_timestamp !== 32'd3) begin n_bad++; $display("FAIL mid_en got %0b %h@%0d want 1 07@3", o_valid, o_port, o_timestamp); end
    endtask

    initial begin
        test_reset();
        test_enable_event();
        test_change();
        test_overflow();
        test_wrap();
        test_en_gate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
